// File: rtl/alu_writeback_stage_if.sv
// Interface bundling the ALU-side input handshake, the register-file-side
// output handshake and the architectural status outputs of alu_writeback_stage.
interface alu_writeback_stage_if #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 4
);
  // ALU side
  logic                      in_valid;
  logic                      in_ready;
  logic [DATA_WIDTH-1:0]     in_data;
  logic                      in_n;
  logic                      in_z;
  logic                      in_c;
  logic                      in_v;
  logic [3:0]                in_cond;
  logic                      in_set_flags;
  logic [REG_ADDR_WIDTH-1:0] in_rd;
  logic                      in_wr_en;
  // Register-file side
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_WIDTH-1:0]     out_data;
  logic [REG_ADDR_WIDTH-1:0] out_rd;
  logic                      out_we;
  // Status
  logic [3:0]                flags_nzcv;
  logic [15:0]               cond_fail_count;

  // Environment: produces ALU results, consumes writebacks
  modport master (
    output in_valid, in_data, in_n, in_z, in_c, in_v, in_cond, in_set_flags, in_rd, in_wr_en,
    output out_ready,
    input  in_ready, out_valid, out_data, out_rd, out_we, flags_nzcv, cond_fail_count
  );

  // Writeback stage
  modport slave (
    input  in_valid, in_data, in_n, in_z, in_c, in_v, in_cond, in_set_flags, in_rd, in_wr_en,
    input  out_ready,
    output in_ready, out_valid, out_data, out_rd, out_we, flags_nzcv, cond_fail_count
  );
endinterface

// File: rtl/alu_writeback_stage.sv
// ALU writeback stage: evaluates the ARM condition code against the flags
// register, updates flags on S-bit instructions that pass, and forwards
// {data, rd, we} to the register file through a 2-entry skid buffer.
// Optional macro ALU_WB_COND_STATS_EN enables a saturating count of
// failed-condition accepts on cond_fail_count (tied to zero otherwise).
module alu_writeback_stage #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 4
) (
  input logic                clk,
  input logic                rst_n,
  alu_writeback_stage_if.slave bus
);

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e                    r_state;
  state_e                    w_state_d;
  logic [3:0]                r_flags;
  logic [DATA_WIDTH-1:0]     r_head_data;
  logic [REG_ADDR_WIDTH-1:0] r_head_rd;
  logic                      r_head_we;
  logic [DATA_WIDTH-1:0]     r_skid_data;
  logic [REG_ADDR_WIDTH-1:0] r_skid_rd;
  logic                      r_skid_we;

  logic w_accept;
  logic w_pass;
  logic w_new_we;
  logic w_load_head_new;
  logic w_load_head_skid;
  logic w_load_skid;

  assign bus.in_ready   = (r_state != StTwo);
  assign w_accept       = bus.in_valid & bus.in_ready;
  assign w_new_we       = bus.in_wr_en & w_pass;
  assign bus.out_valid  = (r_state != StEmpty);
  assign bus.out_data   = r_head_data;
  assign bus.out_rd     = r_head_rd;
  assign bus.out_we     = r_head_we;
  assign bus.flags_nzcv = r_flags;

  // Condition evaluation against the flags held before the accepting edge
  always_comb begin
    logic f_n, f_z, f_c, f_v;
    {f_n, f_z, f_c, f_v} = r_flags;
    w_pass = 1'b0;
    unique case (bus.in_cond)
      4'b0000: w_pass = f_z;
      4'b0001: w_pass = !f_z;
      4'b0010: w_pass = f_c;
      4'b0011: w_pass = !f_c;
      4'b0100: w_pass = f_n;
      4'b0101: w_pass = !f_n;
      4'b0110: w_pass = f_v;
      4'b0111: w_pass = !f_v;
      4'b1000: w_pass = f_c & !f_z;
      4'b1001: w_pass = !f_c | f_z;
      4'b1010: w_pass = (f_n == f_v);
      4'b1011: w_pass = (f_n != f_v);
      4'b1100: w_pass = !f_z & (f_n == f_v);
      4'b1101: w_pass = f_z | (f_n != f_v);
      4'b1110: w_pass = 1'b1;
      4'b1111: w_pass = 1'b0;
    endcase
  end

  // Buffer FSM next state and per-entry load enables
  always_comb begin
    w_state_d        = r_state;
    w_load_head_new  = 1'b0;
    w_load_head_skid = 1'b0;
    w_load_skid      = 1'b0;
    unique case (r_state)
      StEmpty: begin
        if (w_accept) begin
          w_state_d       = StOne;
          w_load_head_new = 1'b1;
        end
      end
      StOne: begin
        if (w_accept && bus.out_ready) begin
          w_load_head_new = 1'b1;
        end else if (w_accept) begin
          w_state_d   = StTwo;
          w_load_skid = 1'b1;
        end else if (bus.out_ready) begin
          w_state_d = StEmpty;
        end
      end
      StTwo: begin
        if (bus.out_ready) begin
          w_state_d        = StOne;
          w_load_head_skid = 1'b1;
        end
      end
      default: w_state_d = StEmpty;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StEmpty;
    else        r_state <= w_state_d;
  end

  // Architectural flags: only passing S-bit instructions update them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags <= 4'b0000;
    end else if (w_accept && w_pass && bus.in_set_flags) begin
      r_flags <= {bus.in_n, bus.in_z, bus.in_c, bus.in_v};
    end
  end

  // Head and skid entry storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head_data <= '0;
      r_head_rd   <= '0;
      r_head_we   <= 1'b0;
      r_skid_data <= '0;
      r_skid_rd   <= '0;
      r_skid_we   <= 1'b0;
    end else begin
      if (w_load_head_new) begin
        r_head_data <= bus.in_data;
        r_head_rd   <= bus.in_rd;
        r_head_we   <= w_new_we;
      end else if (w_load_head_skid) begin
        r_head_data <= r_skid_data;
        r_head_rd   <= r_skid_rd;
        r_head_we   <= r_skid_we;
      end
      if (w_load_skid) begin
        r_skid_data <= bus.in_data;
        r_skid_rd   <= bus.in_rd;
        r_skid_we   <= w_new_we;
      end
    end
  end

`ifdef ALU_WB_COND_STATS_EN
  logic [15:0] r_fail_cnt;

  // Saturating count of accepted instructions whose condition failed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fail_cnt <= 16'h0000;
    end else if (w_accept && !w_pass && (r_fail_cnt != 16'hFFFF)) begin
      r_fail_cnt <= r_fail_cnt + 16'd1;
    end
  end

  assign bus.cond_fail_count = r_fail_cnt;
`else
  assign bus.cond_fail_count = 16'h0000;
`endif

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Directed bench for alu_writeback_stage: reset, condition codes, flag
// updates, skid-buffer backpressure and asynchronous reset from full.
module tb_alu_writeback_stage;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  alu_writeback_stage_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(4)) bus ();

  alu_writeback_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef ALU_WB_COND_STATS_EN
  localparam bit StatsOn = 1'b1;
`else
  localparam bit StatsOn = 1'b0;
`endif

  function automatic logic [15:0] exp_cnt(input int n);
    return StatsOn ? 16'(n) : 16'h0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one ALU result on the input side
  task automatic offer(input logic [31:0] data, input logic [3:0] nzcv, input logic [3:0] cond,
                       input logic sf, input logic [3:0] rd, input logic we);
    bus.in_valid     = 1'b1;
    bus.in_data      = data;
    {bus.in_n, bus.in_z, bus.in_c, bus.in_v} = nzcv;
    bus.in_cond      = cond;
    bus.in_set_flags = sf;
    bus.in_rd        = rd;
    bus.in_wr_en     = we;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    {bus.in_n, bus.in_z, bus.in_c, bus.in_v} = 4'b0000;
    bus.in_cond      = 4'b1110;
    bus.in_set_flags = 1'b0;
    bus.in_rd        = '0;
    bus.in_wr_en     = 1'b0;
    bus.out_ready    = 1'b1;

    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_flags", 32'(bus.flags_nzcv), 32'h0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
    chk("rst_cnt", 32'(bus.cond_fail_count), 32'h0);
    chk("rst_out_data", bus.out_data, 32'h0);
    chk("rst_out_rd", 32'(bus.out_rd), 32'h0);
    chk("rst_out_we", 32'(bus.out_we), 32'h0);

    // AL with S bit sets Z
    @(negedge clk);
    offer(32'h0000_0000, 4'b0100, 4'b1110, 1'b1, 4'd3, 1'b1);
    tick();
    chk("a_valid", 32'(bus.out_valid), 32'h1);
    chk("a_data", bus.out_data, 32'h0);
    chk("a_rd", 32'(bus.out_rd), 32'd3);
    chk("a_we", 32'(bus.out_we), 32'h1);
    chk("a_flags", 32'(bus.flags_nzcv), 32'b0100);

    // EQ passes (Z=1), then NE fails
    offer(32'h0000_0011, 4'b0000, 4'b0000, 1'b0, 4'd4, 1'b1);
    tick();
    chk("eq_data", bus.out_data, 32'h11);
    chk("eq_rd", 32'(bus.out_rd), 32'd4);
    chk("eq_we", 32'(bus.out_we), 32'h1);
    offer(32'h0000_0022, 4'b0000, 4'b0001, 1'b0, 4'd5, 1'b1);
    tick();
    chk("ne_data", bus.out_data, 32'h22);
    chk("ne_we", 32'(bus.out_we), 32'h0);
    chk("ne_cnt", 32'(bus.cond_fail_count), 32'(exp_cnt(1)));
    chk("ne_flags", 32'(bus.flags_nzcv), 32'b0100);

    // Drain
    bus.in_valid = 1'b0;
    tick();
    chk("drain_valid", 32'(bus.out_valid), 32'h0);

    // Backpressure: three offers, two fit
    bus.out_ready = 1'b0;
    offer(32'h0000_0033, 4'b0000, 4'b1110, 1'b0, 4'd6, 1'b1);
    tick();
    chk("bp1_ready", 32'(bus.in_ready), 32'h1);
    chk("bp1_data", bus.out_data, 32'h33);
    offer(32'h0000_0044, 4'b0000, 4'b1110, 1'b0, 4'd7, 1'b1);
    tick();
    chk("bp2_ready", 32'(bus.in_ready), 32'h0);
    chk("bp2_data", bus.out_data, 32'h33);
    offer(32'h0000_0055, 4'b0000, 4'b1110, 1'b0, 4'd8, 1'b1);
    tick();
    chk("bp3_ready", 32'(bus.in_ready), 32'h0);
    chk("bp3_data", bus.out_data, 32'h33);
    chk("bp3_rd", 32'(bus.out_rd), 32'd6);
    bus.out_ready = 1'b1;
    tick();
    chk("bp4_data", bus.out_data, 32'h44);
    chk("bp4_rd", 32'(bus.out_rd), 32'd7);
    chk("bp4_ready", 32'(bus.in_ready), 32'h1);
    tick();
    chk("bp5_data", bus.out_data, 32'h55);
    chk("bp5_rd", 32'(bus.out_rd), 32'd8);
    bus.in_valid = 1'b0;
    tick();
    chk("bp6_valid", 32'(bus.out_valid), 32'h0);

    // N=1, V=0: GE fails, LT passes, NV always fails
    offer(32'h0000_0066, 4'b1000, 4'b1110, 1'b1, 4'd9, 1'b1);
    tick();
    chk("nv_flags", 32'(bus.flags_nzcv), 32'b1000);
    offer(32'h0000_0077, 4'b0000, 4'b1010, 1'b0, 4'd10, 1'b1);
    tick();
    chk("ge_we", 32'(bus.out_we), 32'h0);
    offer(32'h0000_0088, 4'b0000, 4'b1011, 1'b0, 4'd11, 1'b1);
    tick();
    chk("lt_we", 32'(bus.out_we), 32'h1);
    offer(32'h0000_0099, 4'b0000, 4'b1111, 1'b0, 4'd12, 1'b1);
    tick();
    chk("nvc_we", 32'(bus.out_we), 32'h0);
    // Failing S-bit instruction must leave flags alone
    offer(32'h0000_00AA, 4'b0110, 4'b0000, 1'b1, 4'd13, 1'b1);
    tick();
    chk("eqf_flags", 32'(bus.flags_nzcv), 32'b1000);
    chk("eqf_cnt", 32'(bus.cond_fail_count), 32'(exp_cnt(4)));
    // MI passes and sets C; HI then sees C=1, Z=0
    offer(32'h0000_00BB, 4'b0010, 4'b0100, 1'b1, 4'd14, 1'b1);
    tick();
    chk("mi_flags", 32'(bus.flags_nzcv), 32'b0010);
    offer(32'hDEAD_BEEF, 4'b0000, 4'b1000, 1'b0, 4'd15, 1'b1);
    tick();
    chk("hi_we", 32'(bus.out_we), 32'h1);
    chk("hi_data", bus.out_data, 32'hDEAD_BEEF);

    // Fill both entries, then reset asynchronously from full
    bus.in_valid = 1'b0;
    tick();
    bus.out_ready = 1'b0;
    offer(32'h0000_0123, 4'b0000, 4'b1110, 1'b0, 4'd1, 1'b1);
    tick();
    offer(32'h0000_0456, 4'b0000, 4'b1110, 1'b0, 4'd2, 1'b1);
    tick();
    chk("full_ready", 32'(bus.in_ready), 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.out_valid), 32'h0);
    chk("arst_flags", 32'(bus.flags_nzcv), 32'h0);
    chk("arst_cnt", 32'(bus.cond_fail_count), 32'h0);
    chk("arst_data", bus.out_data, 32'h0);
    tick();
    chk("arst_noacc", 32'(bus.out_valid), 32'h0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_valid", 32'(bus.out_valid), 32'h0);
    // Single fresh entry drains alone with no stale skid entry behind it
    bus.out_ready = 1'b1;
    offer(32'h0000_0789, 4'b0000, 4'b1110, 1'b0, 4'd5, 1'b1);
    tick();
    chk("post_data", bus.out_data, 32'h789);
    bus.in_valid = 1'b0;
    tick();
    chk("post_empty", 32'(bus.out_valid), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_writeback_stage.md
Name: alu_writeback_stage

Overview:
- Stage directly downstream of the ALU in the single-cycle datapath.
- Captures each ALU result with its N/Z/C/V flags and the instruction's condition field.
- Evaluates the ARM-style condition against the architectural flags register and updates that register when the condition passes and the set-flags bit is set.
- Forwards the result toward register-file writeback through a 2-entry valid/ready skid buffer.

Parameters:
- DATA_WIDTH, 32, width of ALU result and writeback data
- REG_ADDR_WIDTH, 4, width of destination register index

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  ALU result valid
- in_ready  out  1  stage can accept; equals (state != TWO)
- in_data  in  DATA_WIDTH  ALU data_out
- in_n, in_z, in_c, in_v  in  1 each  ALU flags
- in_cond  in  4  instruction condition code
- in_set_flags  in  1  instruction's S bit
- in_rd  in  REG_ADDR_WIDTH  destination register
- in_wr_en  in  1  instruction writes a register
- out_valid  out  1  head entry valid
- out_ready  in  1  register file accepts head entry
- out_data  out  DATA_WIDTH  writeback data
- out_rd  out  REG_ADDR_WIDTH  writeback register
- out_we  out  1  in_wr_en AND condition passed
- flags_nzcv  out  4  architectural flags {N,Z,C,V}
- cond_fail_count  out  16  see Optional Feature

Behaviour:
- Reset (rst_n low, async): state EMPTY; flags_nzcv=0000; out_valid=0; out_data=0; out_rd=0; out_we=0; skid entry cleared; cond_fail_count=0. No transfer is accepted while rst_n is low. A reset mid-operation discards both buffered entries and any pending flag update.
- Accept = in_valid & in_ready at a rising edge.
- Condition pass is evaluated combinationally against the flags register value before the accepting edge:
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V
  - 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V)
  - 1110 AL 1; 1111 NV 0
- Flag update: on accept with pass & in_set_flags, flags_nzcv <= {in_n,in_z,in_c,in_v} at that edge. A back-to-back accept on the next cycle evaluates against the updated flags, so no hazard exists.
- Failed-condition instructions are still enqueued, with out_we=0, to preserve ordering. Entry = {data, rd, we}.
- Latency: accepted at edge k; out_valid is high after edge k when the buffer was empty.
- Buffer FSM (transitions at each edge):
  - EMPTY: accept -> ONE.
  - ONE: accept & out_ready -> ONE (head replaced by new entry); accept & !out_ready -> TWO (new entry to skid); !accept & out_ready -> EMPTY; else hold.
  - TWO: in_ready=0; out_ready -> ONE (skid moves to head); else hold.
- Output stability: while out_valid & !out_ready, out_data/out_rd/out_we are held stable.
- Widths: data passes through unmodified with no extension or truncation.

Optional Feature:
- Macro: ALU_WB_COND_STATS_EN.
- Defined: cond_fail_count increments by 1 on each accept whose condition fails. It saturates at 16'hFFFF and resets to 0.
- Undefined: counter logic is absent and cond_fail_count is tied to 16'h0000.

Test Plan:
- Reset with rst_n=0, then release -> flags_nzcv=0000, out_valid=0, in_ready=1, cond_fail_count=0.
- Accept data=32'h0000_0000, Z=1, cond=1110, set_flags=1, rd=3, wr_en=1 -> next cycle out_valid=1, out_data=0, out_rd=3, out_we=1, flags_nzcv=0100.
- Immediately follow with cond=0000 (EQ) then cond=0001 (NE), each wr_en=1 -> first out_we=1, second out_we=0. With the feature enabled, cond_fail_count=1.
- Hold out_ready=0 and offer 3 back-to-back entries -> two accepted, in_ready=0 after the second. Raise out_ready -> entries drain in order and the third is accepted.
- Flags N=1,V=0 set; offer cond GE and cond LT -> GE out_we=0, LT out_we=1. Offer cond=1111 -> out_we=0 regardless of flags.
- Assert rst_n=0 while in state TWO -> out_valid=0 and flags_nzcv=0000 immediately (asynchronous), with no stale entry after release.
